groestl_avalon_fifo_slave: RTL and testbench

Avalon-MM slave wrapping groestl_top_pq_parallel, successor to the single-word Groestl component. Host writes 64-bit message words into a parametrised input FIFO, so several words can be queued while the core is busy. Output words are collected into a hash register sized by HS. Status, level and control registers allow software to poll progress or, optionally, take an interrupt.

---
 rtl/groestl_avalon_fifo_slave_if.sv | 41 ++++
 rtl/groestl_avalon_fifo_slave.sv | 194 +++++++++++++++++++
 tb/tb_groestl_avalon_fifo_slave.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/groestl_avalon_fifo_slave_if.sv
// rtl/groestl_avalon_fifo_slave_if.sv - Avalon-MM slave bus and hash-core stream link
//
// Purpose: bundles the host-facing Avalon-MM register bus and the stream link
// to the Groestl hash core so the wrapper sees them as one port.
// Signals:
//   address[4:0], writedata[31:0], byteenable[3:0], write, read, chipselect : host -> slave
//   readdata[31:0]                                                          : slave -> host
//   core_rst, core_din[63:0], core_src_ready, core_dst_ready                : slave -> core
//   core_src_read, core_dout[63:0], core_dst_write                          : core -> slave
// Modports: slave (the wrapper), master (host plus core side, e.g. a bench).
interface groestl_avalon_fifo_slave_if;
  logic [4:0]  address;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        write;
  logic        read;
  logic        chipselect;
  logic [31:0] readdata;

  logic        core_rst;
  logic [63:0] core_din;
  logic        core_src_ready;
  logic        core_src_read;
  logic [63:0] core_dout;
  logic        core_dst_write;
  logic        core_dst_ready;

  modport slave (
    input  address, writedata, byteenable, write, read, chipselect,
    output readdata,
    output core_rst, core_din, core_src_ready, core_dst_ready,
    input  core_src_read, core_dout, core_dst_write
  );

  modport master (
    output address, writedata, byteenable, write, read, chipselect,
    input  readdata,
    input  core_rst, core_din, core_src_ready, core_dst_ready,
    output core_src_read, core_dout, core_dst_write
  );
endinterface

// File: rtl/groestl_avalon_fifo_slave.sv
// rtl/groestl_avalon_fifo_slave.sv - Avalon-MM slave with input FIFO in front of a Groestl core
//
// Purpose: host writes 64-bit message words (two 32-bit halves, optionally
// byte-swapped) into a show-ahead FIFO feeding the hash core; core output words
// are byte-reversed and shifted into an HS-bit hash register.
// Ports:
//   clk      : single clock
//   reset_n  : asynchronous active-low reset
//   bus      : groestl_avalon_fifo_slave_if.slave (Avalon bus + core stream link)
//   irq      : interrupt request, only when GROESTL_IRQ_EN is defined
// Parameters: HS (256/512), FF (core pass-through), FIFO_DEPTH (power of two, >= 2).
// Optional feature macro: GROESTL_IRQ_EN (irq port and stored irq_enable bit).
module groestl_avalon_fifo_slave #(
  parameter int HS         = 512,
  parameter int FF         = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic clk,
  input  logic reset_n,
`ifdef GROESTL_IRQ_EN
  output logic irq,
`endif
  groestl_avalon_fifo_slave_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = HS / 64;
  localparam int CW = $clog2(NW);

  if (HS != 256 && HS != 512) begin : g_bad_hs
    $error("HS must be 256 or 512");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two, at least 2");
  end
  if (FF < 1) begin : g_bad_ff
    $error("FF must be positive");
  end

  logic [31:0] r_stage_lo, r_stage_hi, r_readdata;
  logic [63:0] r_fifo [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0] r_level;
  logic [HS-1:0] r_hash;
  logic [CW-1:0] r_out_cnt;
  logic r_hash_ready, r_ovf, r_soft_rst;

  logic w_wr, w_rd, w_data_wr, w_ctrl_wr, w_push_req, w_push, w_pop;
  logic w_empty, w_full, w_busy, w_last_out, w_irq_en, w_unused;
  logic [31:0] w_wdata_sw, w_stage_val, w_status, w_rdata;
  logic [63:0] w_dout_sw;
  logic [7:0] w_level8;
  logic [31:0] w_hash_word [16];

  assign w_wr       = bus.write & bus.chipselect;
  assign w_rd       = bus.read & bus.chipselect;
  assign w_data_wr  = w_wr & (bus.address[4:2] == 3'b000);
  assign w_ctrl_wr  = w_wr & (bus.address == 5'h05);
  // Odd data addresses complete a word with the high half.
  assign w_push_req = w_data_wr & bus.address[0];
  assign w_wdata_sw = {bus.writedata[7:0], bus.writedata[15:8],
                       bus.writedata[23:16], bus.writedata[31:24]};
  assign w_stage_val = bus.address[1] ? w_wdata_sw : bus.writedata;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == (AW+1)'(FIFO_DEPTH));
  assign w_pop   = bus.core_src_read & ~w_empty;
  // A full FIFO still accepts a word when the core drains one on the same edge.
  assign w_push  = w_push_req & (~w_full | w_pop);
  assign w_busy  = ~w_empty | (r_out_cnt != '0);
  assign w_last_out = bus.core_dst_write & (r_out_cnt == CW'(NW - 1));
  assign w_unused = ^bus.byteenable;

  assign bus.core_rst       = ~reset_n | r_soft_rst;
  assign bus.core_din       = r_fifo[r_rd_ptr];
  assign bus.core_src_ready = w_empty;  // active-low "data available"
  assign bus.core_dst_ready = 1'b0;     // sink never stalls the core
  assign bus.readdata       = r_readdata;

  always_comb begin
    w_dout_sw = '0;
    for (int b = 0; b < 8; b++) w_dout_sw[8*b +: 8] = bus.core_dout[8*(7-b) +: 8];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stage_lo <= '0;
      r_stage_hi <= '0;
    end else if (w_data_wr) begin
      if (bus.address[0]) r_stage_hi <= w_stage_val;
      else                r_stage_lo <= w_stage_val;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= {w_stage_val, r_stage_lo};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (r_soft_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push & ~w_pop)      r_level <= r_level + 1'b1;
      else if (w_pop & ~w_push) r_level <= r_level - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_soft_rst <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_soft_rst <= w_ctrl_wr & bus.writedata[0];
      if (r_soft_rst | (w_ctrl_wr & bus.writedata[1])) r_ovf <= 1'b0;
      else if (w_push_req & w_full & ~w_pop)           r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_cnt    <= '0;
      r_hash_ready <= 1'b0;
    end else if (r_soft_rst) begin
      r_out_cnt    <= '0;
      r_hash_ready <= 1'b0;
    end else begin
      if (bus.core_dst_write) r_out_cnt <= w_last_out ? '0 : r_out_cnt + 1'b1;
      // Completion beats a concurrent host data write.
      if (w_last_out)     r_hash_ready <= 1'b1;
      else if (w_data_wr) r_hash_ready <= 1'b0;
    end
  end

  // Newest output word enters at the top; the first word ends up in hash[63:0].
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                              r_hash <= '0;
    else if (bus.core_dst_write & ~r_soft_rst) r_hash <= {w_dout_sw, r_hash[HS-1:64]};
  end

`ifdef GROESTL_IRQ_EN
  logic r_irq_enable, r_irq;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_enable <= 1'b0;
      r_irq        <= 1'b0;
    end else begin
      if (w_ctrl_wr) r_irq_enable <= bus.writedata[2];
      r_irq <= r_hash_ready & r_irq_enable;
    end
  end
  assign irq      = r_irq;
  assign w_irq_en = r_irq_enable;
`else
  assign w_irq_en = 1'b0;
`endif

  for (genvar gi = 0; gi < 16; gi++) begin : g_hw
    if (32 * gi < HS) begin : g_in
      assign w_hash_word[gi] = r_hash[32*gi +: 32];
    end else begin : g_out
      assign w_hash_word[gi] = '0;
    end
  end

  assign w_level8 = 8'(r_level);
  assign w_status = {16'b0, w_level8, 3'b0, w_busy, r_ovf, w_full, w_empty, r_hash_ready};

  always_comb begin
    w_rdata = '0;
    if (bus.address[4]) begin
      w_rdata = w_hash_word[bus.address[3:0]];
    end else begin
      case (bus.address[3:0])
        4'h0:    w_rdata = r_stage_lo;
        4'h1:    w_rdata = r_stage_hi;
        4'h4:    w_rdata = w_status;
        4'h5:    w_rdata = {29'b0, w_irq_en, 2'b0};
        default: w_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  r_readdata <= '0;
    else if (w_rd) r_readdata <= w_rdata;
  end
endmodule

// File: tb/tb_groestl_avalon_fifo_slave.sv
// tb/tb_groestl_avalon_fifo_slave.sv - scoreboard bench for groestl_avalon_fifo_slave
module tb_groestl_avalon_fifo_slave;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  groestl_avalon_fifo_slave_if bus();
  groestl_avalon_fifo_slave_if bus2();
`ifdef GROESTL_IRQ_EN
  logic irq, irq2;
`endif

  groestl_avalon_fifo_slave #(.HS(512), .FF(8), .FIFO_DEPTH(4)) u_dut (
    .clk(clk),
    .reset_n(reset_n),
`ifdef GROESTL_IRQ_EN
    .irq(irq),
`endif
    .bus(bus)
  );

  groestl_avalon_fifo_slave #(.HS(256), .FF(8), .FIFO_DEPTH(16)) u_dut256 (
    .clk(clk),
    .reset_n(reset_n),
`ifdef GROESTL_IRQ_EN
    .irq(irq2),
`endif
    .bus(bus2)
  );

  typedef struct { string name; logic [31:0] exp; } exp_t;
  exp_t sb[$];
  exp_t sb2[$];
  int total = 0;
  int bad = 0;

  logic [63:0] dig [8] = '{64'h6d3ad29d279110ee, 64'hf3adbd66de2a0345,
                           64'ha77baede1557f5d0, 64'h99fce0c03d6dc2ba,
                           64'h8e6d4a6633dfbd66, 64'h053c20faa87d1a11,
                           64'hf39a7fbe4a6c2f00, 64'h9801370308fc4ad8};

  function automatic void check(string n, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endfunction

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic bus_idle(); bus.write = 0; bus.read = 0; bus.chipselect = 0; endtask
  task automatic issue_wr(logic [4:0] a, logic [31:0] d);
    bus.address = a; bus.writedata = d; bus.write = 1; bus.chipselect = 1;
  endtask
  task automatic issue_rd(logic [4:0] a, logic [31:0] e, string n);
    bus.address = a; bus.read = 1; bus.chipselect = 1; sb.push_back('{n, e});
  endtask
  task automatic wr(logic [4:0] a, logic [31:0] d); issue_wr(a, d); tick(); bus_idle(); endtask
  task automatic rd(logic [4:0] a, logic [31:0] e, string n); issue_rd(a, e, n); tick(); bus_idle(); endtask
  task automatic dst(logic [63:0] d);
    bus.core_dout = d; bus.core_dst_write = 1; tick(); bus.core_dst_write = 0;
  endtask
  task automatic pop(logic [63:0] e, string n);
    @(negedge clk);
    check({n, "_din"}, bus.core_din, e);
    check({n, "_srcrdy"}, {63'b0, bus.core_src_ready}, 64'd0);
    bus.core_src_read = 1; tick(); bus.core_src_read = 0;
  endtask

  task automatic rd2(logic [4:0] a, logic [31:0] e, string n);
    bus2.address = a; bus2.read = 1; bus2.chipselect = 1; sb2.push_back('{n, e});
    tick(); bus2.read = 0; bus2.chipselect = 0;
  endtask
  task automatic dst2(logic [63:0] d);
    bus2.core_dout = d; bus2.core_dst_write = 1; tick(); bus2.core_dst_write = 0;
  endtask

  // Read-response monitors: one response per accepted read, one cycle later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (bus.read && bus.chipselect) begin
        @(negedge clk);
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_underflow: got %h expected no response", bus.readdata);
        end else begin
          e = sb.pop_front();
          check(e.name, {32'b0, bus.readdata}, {32'b0, e.exp});
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (bus2.read && bus2.chipselect) begin
        @(negedge clk);
        if (sb2.size() == 0) begin
          total++; bad++;
          $display("FAIL sb2_underflow: got %h expected no response", bus2.readdata);
        end else begin
          e = sb2.pop_front();
          check(e.name, {32'b0, bus2.readdata}, {32'b0, e.exp});
        end
      end
    end
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    bus.address = 0; bus.writedata = 0; bus.byteenable = 4'h1; bus_idle();
    bus.core_src_read = 0; bus.core_dout = 0; bus.core_dst_write = 0;
    bus2.address = 0; bus2.writedata = 0; bus2.byteenable = 4'h0;
    bus2.write = 0; bus2.read = 0; bus2.chipselect = 0;
    bus2.core_src_read = 0; bus2.core_dout = 0; bus2.core_dst_write = 0;

    repeat (3) @(posedge clk);
    #1 reset_n = 1;
    check("init_readdata", {32'b0, bus.readdata}, 64'd0);

    // Reset mid-operation with a word queued and readdata non-zero
    wr(5'h00, 32'h8000_0000);
    wr(5'h01, 32'h0000_0000);
    rd(5'h00, 32'h8000_0000, "pre_rst_stage_lo");
    tick();
    #2 reset_n = 0;
    @(negedge clk);
    check("rst_readdata", {32'b0, bus.readdata}, 64'd0);
    check("rst_core_rst", {63'b0, bus.core_rst}, 64'd1);
    check("rst_src_ready", {63'b0, bus.core_src_ready}, 64'd1);
    tick();
    reset_n = 1;
    tick();
    rd(5'h04, 32'h0000_0002, "rst_status");
    rd(5'h00, 32'h0, "rst_stage_lo");
    rd(5'h01, 32'h0, "rst_stage_hi");

    // Single word
    wr(5'h00, 32'h8000_0000);
    wr(5'h01, 32'h0000_0000);
    rd(5'h04, 32'h0000_0110, "sw_status");
    pop(64'h0000_0000_8000_0000, "sw");
    rd(5'h04, 32'h0000_0002, "sw_status_after");
    @(negedge clk);
    check("sw_src_ready", {63'b0, bus.core_src_ready}, 64'd1);
    tick();

    // chipselect gates both writes and reads
    bus.address = 5'h00; bus.writedata = 32'hdead_beef; bus.write = 1;
    tick(); bus_idle();
    rd(5'h00, 32'h8000_0000, "cs_gate_wr");
    bus.address = 5'h04; bus.read = 1;
    tick(); bus_idle();
    @(negedge clk);
    check("cs_gate_rd", {32'b0, bus.readdata}, 64'h8000_0000);
    tick();

    // Overflow on a 4-deep FIFO, core not draining
    for (int i = 0; i < 5; i++) begin
      wr(5'h00, 32'h1000_0000 + i);
      wr(5'h01, 32'h2000_0000 + i);
    end
    rd(5'h04, 32'h0000_041C, "ovf_status");
    wr(5'h05, 32'h2);
    rd(5'h04, 32'h0000_0414, "ovf_clear");
    wr(5'h00, 32'h1000_0005);
    bus.core_src_read = 1;
    wr(5'h01, 32'h2000_0005);
    bus.core_src_read = 0;
    rd(5'h04, 32'h0000_0414, "full_push_pop");
    pop(64'h2000_0001_1000_0001, "drain1");
    pop(64'h2000_0002_1000_0002, "drain2");
    pop(64'h2000_0003_1000_0003, "drain3");
    pop(64'h2000_0005_1000_0005, "drain5");
    rd(5'h04, 32'h0000_0002, "drained");

    // Padded empty-message block through the swap addresses
    for (int k = 0; k < 16; k++) begin
      wr(5'h02, (k == 0)  ? 32'h0000_0080 : 32'h0);
      wr(5'h03, (k == 15) ? 32'h0100_0000 : 32'h0);
      if (k == 0)       pop(64'h0000_0000_8000_0000, "blk_first");
      else if (k == 15) pop(64'h0000_0001_0000_0000, "blk_last");
      else              pop(64'h0, "blk_mid");
    end
    for (int k = 0; k < 8; k++) begin
      if (k == 7) issue_rd(5'h04, 32'h0000_0012, "hash_last_cycle");
      dst(dig[k]);
      if (k == 7) bus_idle();
    end
    rd(5'h04, 32'h0000_0003, "hash_ready");
    rd(5'h10, 32'h9dd2_3a6d, "hash_w0");
    rd(5'h11, 32'hee10_9127, "hash_w1");
    rd(5'h1F, 32'hd84a_fc08, "hash_w15");

    // Completion and host data write on the same edge: completion wins
    for (int k = 0; k < 8; k++) begin
      if (k == 7) issue_wr(5'h00, 32'h55);
      dst(dig[k]);
      if (k == 7) bus_idle();
    end
    rd(5'h04, 32'h0000_0003, "set_wins");
    wr(5'h00, 32'h1);
    rd(5'h04, 32'h0000_0002, "host_clear");

    // Soft reset with words queued and a partial output count
    for (int i = 0; i < 3; i++) begin
      wr(5'h00, 32'h3000_0000 + i);
      wr(5'h01, 32'h4000_0000 + i);
    end
    for (int k = 0; k < 3; k++) dst(dig[k]);
    rd(5'h10, 32'hc0e0_fc99, "pre_srst_hash");
    rd(5'h04, 32'h0000_0310, "pre_srst_status");
    wr(5'h05, 32'h1);
    @(negedge clk);
    check("srst_core_rst", {63'b0, bus.core_rst}, 64'd1);
    tick();
    rd(5'h04, 32'h0000_0002, "srst_status");
    rd(5'h10, 32'hc0e0_fc99, "srst_hash_kept");
    for (int k = 0; k < 7; k++) dst(dig[k]);
    rd(5'h04, 32'h0000_0012, "srst_cnt7");
    dst(dig[7]);
    rd(5'h04, 32'h0000_0003, "srst_cnt8");

`ifdef GROESTL_IRQ_EN
    wr(5'h00, 32'h0);
    wr(5'h05, 32'h4);
    rd(5'h05, 32'h0000_0004, "ctrl_rd_irq");
    for (int k = 0; k < 8; k++) dst(dig[k]);
    @(negedge clk);
    check("irq_not_yet", {63'b0, irq}, 64'd0);
    tick();
    @(negedge clk);
    check("irq_set", {63'b0, irq}, 64'd1);
    tick();
    wr(5'h00, 32'h0);
    tick();
    @(negedge clk);
    check("irq_cleared", {63'b0, irq}, 64'd0);
    tick();
`else
    wr(5'h05, 32'h4);
    rd(5'h05, 32'h0, "ctrl_rd_noirq");
`endif

    // Reset after a completed hash clears the hash register
    reset_n = 0;
    tick();
    reset_n = 1;
    tick();
    rd(5'h10, 32'h0, "rst_hash");
    rd(5'h04, 32'h0000_0002, "rst_status2");

    // HS=256 instance: four output words, upper hash window reads zero
    for (int k = 0; k < 4; k++) dst2(dig[k]);
    rd2(5'h04, 32'h0000_0003, "h256_status");
    rd2(5'h10, 32'h9dd2_3a6d, "h256_w0");
    rd2(5'h17, 32'hbac2_6d3d, "h256_w7");
    rd2(5'h18, 32'h0, "h256_w8");
    rd2(5'h1F, 32'h0, "h256_w15");

    repeat (4) tick();
    check("sb_drained", 64'(sb.size() + sb2.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
